// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer for a 2-input NOR gate: applies 00,01,10,11, counts mismatches.
// Optional macro GATE_TT_SEQ_LOOP_EN lets DONE re-enter DRIVE directly while start stays high.
module gate_tt_sequencer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a,
  output logic       b,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_r;
  logic [7:0] hold_cnt_r;
  logic       sample_s;
  logic [2:0] err_next_s;
  logic [1:0] vec_next_s;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    if (v == 3'd7) begin
      return 3'd7;
    end else begin
      return v + 3'd1;
    end
  endfunction

  // Sample strobe and the error count that results from this cycle's compare
  always_comb begin
    sample_s   = 1'b0;
    err_next_s = err_cnt;
    vec_next_s = vec_idx + 2'd1;
    if ((state_r == DRIVE) && (hold_cnt_r == HOLD_LAST)) begin
      sample_s = 1'b1;
    end else begin
      sample_s = 1'b0;
    end
    if (sample_s && (y_in != ~(a | b))) begin
      err_next_s = sat_inc3(err_cnt);
    end else begin
      err_next_s = err_cnt;
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      hold_cnt_r <= 8'd0;
      a          <= 1'b0;
      b          <= 1'b0;
      vec_idx    <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          a    <= 1'b0;
          b    <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state_r    <= DRIVE;
            vec_idx    <= 2'd0;
            hold_cnt_r <= 8'd0;
            err_cnt    <= 3'd0;
            pass       <= 1'b0;
            busy       <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        DRIVE: begin
          if (sample_s) begin
            err_cnt    <= err_next_s;
            hold_cnt_r <= 8'd0;
            if (vec_idx == 2'd3) begin
              // Pass verdict includes the final sample taken on this edge
              state_r <= DONE;
              done    <= 1'b1;
              pass    <= (err_next_s == 3'd0);
            end else begin
              vec_idx <= vec_next_s;
              a       <= vec_next_s[1];
              b       <= vec_next_s[0];
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
          end
        end
        DONE: begin
          done <= 1'b0;
`ifdef GATE_TT_SEQ_LOOP_EN
          if (start) begin
            state_r    <= DRIVE;
            vec_idx    <= 2'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            hold_cnt_r <= 8'd0;
            busy       <= 1'b1;
          end else begin
            state_r <= IDLE;
            a       <= 1'b0;
            b       <= 1'b0;
            busy    <= 1'b0;
          end
`else
          state_r <= IDLE;
          a       <= 1'b0;
          b       <= 1'b0;
          busy    <= 1'b0;
`endif
        end
        default: begin
          state_r    <= IDLE;
          hold_cnt_r <= 8'd0;
          a          <= 1'b0;
          b          <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Self-checking bench for gate_tt_sequencer: table vectors, random truth tables, reset and loop corners.
module tb_gate_tt_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1, y_in;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [1:0] vi0, vi1;
  logic [2:0] e0, e1;

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;

  logic [1:0] o_ab, o_vi;
  logic       o_busy, o_done, o_pass;
  logic [2:0] o_err;

  always #5 clk = ~clk;

  gate_tt_sequencer #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start0), .y_in(y_in), .a(a0), .b(b0),
    .vec_idx(vi0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(e0)
  );

  gate_tt_sequencer #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .y_in(y_in), .a(a1), .b(b1),
    .vec_idx(vi1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(e1)
  );

  always_comb begin
    if (sel != 0) begin
      o_ab = {a1, b1}; o_vi = vi1; o_busy = busy1; o_done = done1; o_pass = pass1; o_err = e1;
    end else begin
      o_ab = {a0, b0}; o_vi = vi0; o_busy = busy0; o_done = done0; o_pass = pass0; o_err = e0;
    end
  end

  typedef struct {
    logic [3:0] tt;
    logic [2:0] exp_err;
    logic       exp_pass;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel != 0) start1 = v;
    else          start0 = v;
  endtask

  // Reference: tt[v] is the gate's output for {a,b}==v; correct NOR is 1 only at v==0
  function automatic int model_err(input logic [3:0] tt);
    int e = 0;
    for (int v = 0; v < 4; v++) begin
      if (tt[v] != (v == 0)) e++;
    end
    if (e > 7) e = 7;
    return e;
  endfunction

  // One pass with start held through the busy phase; y_in is random except on sample cycles
  task automatic run_pass(input string tag, input logic [3:0] tt,
                          input logic [2:0] exp_err, input logic exp_pass);
    int h;
    h = (sel != 0) ? 1 : 4;
    @(negedge clk);
    drive_start(1'b1);
    y_in = 1'($urandom);
    for (int k = 1; k <= 4 * h; k++) begin
      @(negedge clk);
      chk({tag, " ab"}, 32'(o_ab), 32'((k - 1) / h));
      chk({tag, " vec_idx"}, 32'(o_vi), 32'((k - 1) / h));
      chk({tag, " busy"}, 32'(o_busy), 32'd1);
      chk({tag, " done early"}, 32'(o_done), 32'd0);
      if (k == 1) begin
        chk({tag, " err cleared"}, 32'(o_err), 32'd0);
        chk({tag, " pass cleared"}, 32'(o_pass), 32'd0);
      end
      if ((k % h) == 0) y_in = tt[(k / h) - 1];
      else              y_in = 1'($urandom);
    end
    @(negedge clk);
    chk({tag, " done"}, 32'(o_done), 32'd1);
    chk({tag, " busy in done"}, 32'(o_busy), 32'd1);
    chk({tag, " vec_idx hold"}, 32'(o_vi), 32'd3);
    chk({tag, " err"}, 32'(o_err), 32'(exp_err));
    chk({tag, " pass"}, 32'(o_pass), 32'(exp_pass));
    drive_start(1'b0);
    y_in = 1'($urandom);
    @(negedge clk);
    chk({tag, " done pulse end"}, 32'(o_done), 32'd0);
    chk({tag, " idle busy"}, 32'(o_busy), 32'd0);
    chk({tag, " idle ab"}, 32'(o_ab), 32'd0);
    chk({tag, " pass held"}, 32'(o_pass), 32'(exp_pass));
    chk({tag, " err held"}, 32'(o_err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int seen_done;
    logic [3:0] rtt;

    tbl[0] = '{tt: 4'b0001, exp_err: 3'd0, exp_pass: 1'b1};  // correct NOR
    tbl[1] = '{tt: 4'b0000, exp_err: 3'd1, exp_pass: 1'b0};  // stuck at 0
    tbl[2] = '{tt: 4'b1110, exp_err: 3'd4, exp_pass: 1'b0};  // OR instead of NOR
    tbl[3] = '{tt: 4'b1111, exp_err: 3'd3, exp_pass: 1'b0};  // stuck at 1
    tbl[4] = '{tt: 4'b0110, exp_err: 3'd3, exp_pass: 1'b0};  // XOR

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; y_in = 1'b0;
    #12;
    chk("reset outputs dut", 32'({a0, b0, vi0, busy0, done0, pass0, e0}), 32'd0);
    chk("reset outputs dut1", 32'({a1, b1, vi1, busy1, done1, pass1, e1}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < 2; s++) begin
        sel = s;
        run_pass($sformatf("tbl%0d h%0d", i, (s != 0) ? 1 : 4), tbl[i].tt, tbl[i].exp_err, tbl[i].exp_pass);
      end
    end

    for (int i = 0; i < 8; i++) begin
      sel = i % 2;
      rtt = 4'($urandom);
      run_pass($sformatf("rand%0d tt%0h", i, rtt), rtt, 3'(model_err(rtt)), model_err(rtt) == 0);
    end

    // Abort a pass with reset while the third vector is applied
    sel = 0;
    y_in = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort pre vec_idx", 32'(vi0), 32'd2);
    chk("abort pre err", 32'(e0), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async reset outputs", 32'({a0, b0, vi0, busy0, done0, pass0, e0}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0) seen_done++;
    end
    chk("abort no done", 32'(seen_done), 32'd0);
    chk("abort pass low", 32'(pass0), 32'd0);
    run_pass("after abort", 4'b0001, 3'd0, 1'b1);

`ifdef GATE_TT_SEQ_LOOP_EN
    begin
      int dn;
      int errs[3];
      dn = 0;
      sel = 0;
      y_in = 1'b1;
      @(negedge clk); start0 = 1'b1;
      for (int c = 0; c < 70; c++) begin
        @(negedge clk);
        if (done0) begin
          if (dn < 3) errs[dn] = int'(e0);
          dn++;
          if (dn == 3) begin
            chk("loop pass3 pass", 32'(pass0), 32'd0);
            start0 = 1'b0;
          end
        end
      end
      chk("loop done count", 32'(dn), 32'd3);
      chk("loop err pass1", 32'(errs[0]), 32'd3);
      chk("loop err pass2", 32'(errs[1]), 32'd6);
      chk("loop err pass3", 32'(errs[2]), 32'd7);
      chk("loop back idle", 32'(busy0), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
